// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg: shared FSM state type for the AFifo write-port arbiter
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester handshake plus FIFO write-port bundle; master = producers/FIFO, slave = arbiter
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int data_width = 8
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*data_width-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [data_width-1:0]         fifo_wr_data;
    logic                          busy;
    logic [ID_W-1:0]               active_id;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, busy, active_id
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data, busy, active_id
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set bit of req scanning upward from last+1
module rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               any,
    output logic [ID_W-1:0]    win
);

    logic [NUM_REQ-1:0] sh;
    logic [ID_W:0]      base;
    logic [ID_W:0]      off;
    logic [ID_W:0]      sum;

    // Rotate via the doubled vector so index 0 of sh is last+1; lowest set offset wins.
    always_comb begin
        base = {1'b0, last} + 1'b1;
        sh   = NUM_REQ'({req, req} >> base);
        any  = |req;
        off  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (sh[i]) off = (ID_W+1)'(i);
        sum = base + off;
        win = ID_W'(sum >= (ID_W+1)'(NUM_REQ) ? sum - (ID_W+1)'(NUM_REQ) : sum);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter for the AFifo write port; define ARB_BURST_LOCK_EN for packet-atomic grants
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int data_width = 8,
    parameter int MAX_BURST  = 4
) (
    input logic             wr_clk,
    input logic             rst_n,
    fifo_wr_arbiter_if.slave bus
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t                state;
    logic [ID_W-1:0]       owner;
    logic [ID_W-1:0]       last_owner;
    logic [CNT_W-1:0]      cnt;
    logic                  any;
    logic [ID_W-1:0]       win;
    logic                  own_valid;
    logic                  own_last;
    logic [data_width-1:0] own_data;
    logic                  acc;
    logic                  rel;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req  (bus.req_valid),
        .last (last_owner),
        .any  (any),
        .win  (win)
    );

    // Select the owner's lane, decide acceptance and whether this cycle ends the grant.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (owner == ID_W'(i)) begin
                own_valid = bus.req_valid[i];
                own_last  = bus.req_last[i];
                own_data  = bus.req_data[i*data_width +: data_width];
            end
        acc = (state == ST_XFER) && own_valid && !bus.fifo_full;
`ifdef ARB_BURST_LOCK_EN
        rel = acc && own_last;
`else
        rel = (acc && (own_last || cnt == CNT_W'(MAX_BURST - 1))) || (state == ST_XFER && !own_valid);
`endif
    end

    // Drive the handshake and FIFO write port; everything idles to zero outside XFER.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            bus.req_ready[i] = (state == ST_XFER) && !bus.fifo_full && owner == ID_W'(i);
        bus.fifo_wr_en   = acc;
        bus.fifo_wr_data = acc ? own_data : '0;
    end

    // Grant FSM: arbitrate in IDLE, count accepted words in XFER, release back to IDLE.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            owner         <= '0;
            last_owner    <= ID_W'(NUM_REQ - 1);
            cnt           <= '0;
            bus.busy      <= 1'b0;
            bus.active_id <= '0;
        end else if (state == ST_IDLE) begin
            if (any) begin
                state         <= ST_XFER;
                owner         <= win;
                cnt           <= '0;
                bus.busy      <= 1'b1;
                bus.active_id <= win;
            end
        end else begin
            if (acc && cnt != CNT_W'(MAX_BURST))
                cnt <= cnt + 1'b1;
            if (rel) begin
                state      <= ST_IDLE;
                last_owner <= owner;
                bus.busy   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized checks of fifo_wr_arbiter against a grant-level reference model
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
`ifdef ARB_BURST_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic wr_clk = 1'b0;
    logic rst_n  = 1'b0;
    logic full_v = 1'b0;

    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .data_width(DW)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(N), .data_width(DW), .MAX_BURST(MB)) dut (
        .wr_clk (wr_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    logic [DW:0]      pq [N][64];
    int               hd [N];
    int               tl [N];
    int               n_vec = 0;
    int               n_err = 0;
    bit               m_busy;
    int               m_own, m_last, m_cnt;
    int               acc_cnt = 0;
    int               wr_cnt  = 0;
    int               log_id[$];
    logic [DW-1:0]    log_dat[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [DW-1:0] d, input bit l);
        pq[i][tl[i] % 64] = {l, d};
        tl[i]++;
    endtask

    function automatic int pend(input int i);
        return tl[i] - hd[i];
    endfunction

    function automatic logic [DW-1:0] tag(input int id, input int seq);
        return {2'(id), 6'(seq)};
    endfunction

    // One clock: present queued words, check DUT against the model, advance the model.
    task automatic tick();
        logic [N-1:0]  er;
        logic          ea;
        logic [DW-1:0] ed;
        logic [DW:0]   w;
        bit            ol, rel;
        for (int i = 0; i < N; i++) begin
            w = pend(i) > 0 ? pq[i][hd[i] % 64] : '0;
            bus.req_valid[i]           = pend(i) > 0;
            bus.req_last[i]            = w[DW];
            bus.req_data[i*DW +: DW]   = w[DW-1:0];
        end
        bus.fifo_full = full_v;
        #1;
        ea = m_busy && bus.req_valid[m_own] && !full_v;
        ol = bus.req_last[m_own];
        er = '0;
        if (m_busy && !full_v) er[m_own] = 1'b1;
        ed = ea ? bus.req_data[m_own*DW +: DW] : '0;
        chk("wr_en", bus.fifo_wr_en, ea);
        chk("wr_data", bus.fifo_wr_data, ed);
        chk("req_ready", bus.req_ready, er);
        chk("busy", bus.busy, m_busy);
        chk("active_id", bus.active_id, m_own);
        chk("write_while_full", bus.fifo_wr_en & full_v, 0);
        if (bus.fifo_wr_en) begin
            wr_cnt++;
            log_id.push_back(int'(bus.active_id));
            log_dat.push_back(bus.fifo_wr_data);
        end
        if (!m_busy) begin
            if (bus.req_valid != '0) begin
                for (int k = 1; k <= N; k++)
                    if (bus.req_valid[(m_last + k) % N]) begin
                        m_own = (m_last + k) % N;
                        break;
                    end
                m_cnt  = 0;
                m_busy = 1'b1;
            end
        end else begin
            if (ea) begin
                m_cnt = m_cnt < MB ? m_cnt + 1 : MB;
                hd[m_own]++;
                acc_cnt++;
            end
            if (LOCK) rel = ea && ol;
            else      rel = (ea && (ol || m_cnt == MB)) || !bus.req_valid[m_own];
            if (rel) begin
                m_busy = 1'b0;
                m_last = m_own;
            end
        end
        @(posedge wr_clk);
        #1;
    endtask

    // Asynchronous reset from wherever we are; outputs must drop at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_wr_en", bus.fifo_wr_en, 0);
        chk("rst_wr_data", bus.fifo_wr_data, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_active_id", bus.active_id, 0);
        for (int i = 0; i < N; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        full_v = 1'b0;
        log_id.delete();
        log_dat.delete();
        @(posedge wr_clk);
        #1;
        rst_n  = 1'b1;
        m_busy = 1'b0;
        m_own  = 0;
        m_last = N - 1;
        m_cnt  = 0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        do_reset();

        // Reset in the middle of a burst, then the first grant must go to 0.
        for (int k = 0; k < 4; k++) push(2, tag(2, k), 1'b0);
        tick();
        tick();
        chk("t1_busy_before_reset", bus.busy, 1);
        do_reset();
        for (int i = 0; i < N; i++) push(i, tag(i, 0), 1'b1);
        tick();
        tick();
        chk("t1_first_grant", log_id.size() > 0 ? log_id[0] : -1, 0);
        do_reset();

        // All requesters busy: 0,1,2,3,0 each for four words with one idle cycle between.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 8; k++) push(i, tag(i, k), LOCK && (k % 4 == 3));
        for (int c = 0; c < 25; c++) tick();
        chk("t2_write_count", log_id.size(), 20);
        for (int j = 0; j < 20 && j < log_id.size(); j++) begin
            chk("t2_grant_id", log_id[j], (j / 4) % 4);
            chk("t2_word", log_dat[j], tag((j / 4) % 4, (j / 16) * 4 + j % 4));
        end
        do_reset();

        // Short packet from 2 releases on its last word; rotation resumes at 3.
        for (int k = 0; k < 3; k++) push(2, tag(2, k), k == 2);
        tick();
        push(0, tag(0, 0), 1'b1);
        push(1, tag(1, 0), 1'b1);
        push(3, tag(3, 0), 1'b1);
        for (int c = 0; c < 10; c++) tick();
        chk("t3_write_count", log_id.size(), 6);
        for (int j = 0; j < 6 && j < log_id.size(); j++)
            chk("t3_grant_id", log_id[j], j < 3 ? 2 : (j == 3 ? 3 : j - 4));
        do_reset();

        // Full stall in the middle of requester 1's burst.
        for (int k = 0; k < 4; k++) push(1, tag(1, k), LOCK && k == 3);
        tick();
        tick();
        tick();
        full_v = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.fifo_full = 1'b1;
            #1;
            chk("t4_stall_wr_en", bus.fifo_wr_en, 0);
            chk("t4_stall_ready", bus.req_ready[1], 0);
            chk("t4_stall_busy", bus.busy, 1);
            tick();
        end
        full_v = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        chk("t4_write_count", log_id.size(), 4);
        for (int j = 0; j < 4 && j < log_id.size(); j++) begin
            chk("t4_grant_id", log_id[j], 1);
            chk("t4_word", log_dat[j], tag(1, j));
        end
        do_reset();

        // Owner gap: releases by default, held when grants are packet-atomic.
        push(0, tag(0, 0), 1'b0);
        push(1, tag(1, 0), 1'b1);
        tick();
        tick();
        tick();
        push(0, tag(0, 1), 1'b1);
        for (int c = 0; c < 6; c++) tick();
        chk("t5_write_count", log_id.size(), 3);
        if (log_id.size() == 3) begin
            chk("t5_grant_id0", log_id[0], 0);
            chk("t5_grant_id1", log_id[1], LOCK ? 0 : 1);
            chk("t5_grant_id2", log_id[2], LOCK ? 1 : 0);
        end
        do_reset();

        // Random traffic and back-pressure against the model.
        acc_cnt = 0;
        wr_cnt  = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++)
                if (pend(i) < 4 && $urandom_range(0, 9) < 3)
                    push(i, DW'($urandom), $urandom_range(0, 3) == 0);
            full_v = $urandom_range(0, 4) == 0;
            tick();
        end
        chk("t6_stream_length", wr_cnt, acc_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
